// File: rtl/pg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pg_pkg
// Brief    : Shared mode/state encodings for the multi-channel pulse generator.
// Revision : 1.0
// ============================================================================
package pg_pkg;

    localparam logic [1:0] PG_MODE_STOP  = 2'd0;
    localparam logic [1:0] PG_MODE_CONT  = 2'd1;
    localparam logic [1:0] PG_MODE_BURST = 2'd2;

    localparam logic [0:0] PG_ST_IDLE = 1'b0;
    localparam logic [0:0] PG_ST_RUN  = 1'b1;

    // A run starts on continuous mode, or on a trigger while in burst mode.
    function automatic logic pg_start_req(input logic [1:0] mode, input logic trig);
        return (mode == PG_MODE_CONT) || ((mode == PG_MODE_BURST) && trig);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pg_channel.sv
`default_nettype none
// ============================================================================
// Module   : pg_channel
// Brief    : One pulse channel: window compare, enable gating, polarity, output register.
// Revision : 1.0
// ============================================================================
module pg_channel #(
    parameter int CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_res_n,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_busy,
    input  logic [CNT_W-1:0] i_st,
    input  logic [CNT_W-1:0] i_end,
    input  logic             i_pol,
    input  logic             i_en,
    output logic             o_pulse
);

    logic w_raw;
    logic r_pulse;

    // Half-open window [st, end); st >= end yields an empty window.
    assign w_raw = (i_st <= i_cnt) && (i_cnt < i_end);

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= (w_raw && i_en && i_busy) ^ i_pol;
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/pg_multi_core.sv
`default_nettype none
// ============================================================================
// Module   : pg_multi_core
// Brief    : Shared period counter with stop/continuous/burst modes and
//            double-buffered configuration driving CH_NUM pulse channels.
// Revision : 1.0
// ============================================================================
module pg_multi_core
    import pg_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int CNT_W   = 24,
    parameter int BURST_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_res_n,
    input  logic [1:0]              i_mode,
    input  logic                    i_trig,
    input  logic                    i_load,
    input  logic [CNT_W-1:0]        i_period,
    input  logic [BURST_W-1:0]      i_burst_len,
    input  logic [CH_NUM*CNT_W-1:0] i_st,
    input  logic [CH_NUM*CNT_W-1:0] i_end,
    input  logic [CH_NUM-1:0]       i_pol,
    input  logic [CH_NUM-1:0]       i_ch_en,
    output logic [CH_NUM-1:0]       o_pulse,
    output logic [CNT_W-1:0]        o_cnt,
    output logic                    o_period_stb,
    output logic                    o_busy,
    output logic                    o_done
);

    logic [0:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [BURST_W-1:0]      r_burst_cnt;
    logic                    r_period_stb;
    logic                    r_done;
    logic                    r_pending;

    logic [CNT_W-1:0]        r_sh_period;
    logic [BURST_W-1:0]      r_sh_burst_len;
    logic [CH_NUM*CNT_W-1:0] r_sh_st;
    logic [CH_NUM*CNT_W-1:0] r_sh_end;
    logic [CH_NUM-1:0]       r_sh_pol;
    logic [CH_NUM-1:0]       r_sh_en;

    logic [CNT_W-1:0]        r_act_period;
    logic [BURST_W-1:0]      r_act_burst_len;
    logic [CH_NUM*CNT_W-1:0] r_act_st;
    logic [CH_NUM*CNT_W-1:0] r_act_end;
    logic [CH_NUM-1:0]       r_act_pol;
    logic [CH_NUM-1:0]       r_act_en;

    logic                    w_run;
    logic                    w_wrap;
    logic                    w_start;
    logic [BURST_W-1:0]      w_burst_last;
    logic                    w_burst_more;
    logic                    w_stay;
    logic                    w_apply;

    assign w_run   = (r_state == PG_ST_RUN);
    assign w_wrap  = w_run && (r_cnt == r_act_period);
    assign w_start = !w_run && pg_start_req(i_mode, i_trig);

    // A burst length of 0 behaves as 1, so the last index saturates at 0.
    assign w_burst_last = (r_act_burst_len == '0) ? '0 : (r_act_burst_len - 1'b1);
    assign w_burst_more = (r_burst_cnt < w_burst_last);
    assign w_stay       = (i_mode == PG_MODE_CONT) ||
                          ((i_mode == PG_MODE_BURST) && w_burst_more);

    assign w_apply = (!w_run || w_wrap) && r_pending;

    // Mode is only consulted at wrap, so a period is never cut short.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_state      <= PG_ST_IDLE;
            r_cnt        <= '0;
            r_burst_cnt  <= '0;
            r_period_stb <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (!w_run) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
                if (w_start) begin
                    r_state      <= PG_ST_RUN;
                    r_burst_cnt  <= '0;
                    r_period_stb <= 1'b1;
                end else begin
                    r_period_stb <= 1'b0;
                end
            end else if (w_wrap) begin
                r_cnt <= '0;
                if (w_stay) begin
                    r_period_stb <= 1'b1;
                    r_done       <= 1'b0;
                    if (i_mode == PG_MODE_BURST) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end else begin
                    r_state      <= PG_ST_IDLE;
                    r_period_stb <= 1'b0;
                    r_done       <= (i_mode == PG_MODE_BURST);
                end
            end else begin
                r_cnt        <= r_cnt + 1'b1;
                r_period_stb <= 1'b0;
                r_done       <= 1'b0;
            end
        end
    end

    // Shadow always captures on load; active follows immediately in IDLE,
    // otherwise only on a wrap with an outstanding load.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_sh_period     <= '0;
            r_sh_burst_len  <= '0;
            r_sh_st         <= '0;
            r_sh_end        <= '0;
            r_sh_pol        <= '0;
            r_sh_en         <= '0;
            r_act_period    <= '0;
            r_act_burst_len <= '0;
            r_act_st        <= '0;
            r_act_end       <= '0;
            r_act_pol       <= '0;
            r_act_en        <= '0;
            r_pending       <= 1'b0;
        end else begin
            if (i_load) begin
                r_sh_period    <= i_period;
                r_sh_burst_len <= i_burst_len;
                r_sh_st        <= i_st;
                r_sh_end       <= i_end;
                r_sh_pol       <= i_pol;
                r_sh_en        <= i_ch_en;
            end
            if (!w_run && i_load) begin
                r_act_period    <= i_period;
                r_act_burst_len <= i_burst_len;
                r_act_st        <= i_st;
                r_act_end       <= i_end;
                r_act_pol       <= i_pol;
                r_act_en        <= i_ch_en;
                r_pending       <= 1'b0;
            end else begin
                if (w_apply) begin
                    r_act_period    <= r_sh_period;
                    r_act_burst_len <= r_sh_burst_len;
                    r_act_st        <= r_sh_st;
                    r_act_end       <= r_sh_end;
                    r_act_pol       <= r_sh_pol;
                    r_act_en        <= r_sh_en;
                end
                if (i_load) begin
                    r_pending <= 1'b1;
                end else if (w_apply) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
            pg_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .i_clk   (i_clk),
                .i_res_n (i_res_n),
                .i_cnt   (r_cnt),
                .i_busy  (w_run),
                .i_st    (r_act_st[k*CNT_W +: CNT_W]),
                .i_end   (r_act_end[k*CNT_W +: CNT_W]),
                .i_pol   (r_act_pol[k]),
                .i_en    (r_act_en[k]),
                .o_pulse (o_pulse[k])
            );
        end
    endgenerate

    assign o_cnt        = r_cnt;
    assign o_busy       = w_run;
    assign o_period_stb = r_period_stb;
    assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pg_multi_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pg_multi_core
// Brief    : Event scoreboard bench for pg_multi_core (strobes, done, pulse edges).
// Revision : 1.0
// ============================================================================
module tb_pg_multi_core;

    localparam int CH_NUM  = 4;
    localparam int CNT_W   = 24;
    localparam int BURST_W = 8;

    localparam int K_STB   = 0;
    localparam int K_DONE  = 1;
    localparam int K_PULSE = 2;

    logic                    clk = 1'b0;
    logic                    res_n;
    logic [1:0]              mode;
    logic                    trig;
    logic                    load;
    logic [CNT_W-1:0]        period;
    logic [BURST_W-1:0]      burst_len;
    logic [CH_NUM*CNT_W-1:0] st_v;
    logic [CH_NUM*CNT_W-1:0] end_v;
    logic [CH_NUM-1:0]       pol_v;
    logic [CH_NUM-1:0]       en_v;
    logic [CH_NUM-1:0]       pulse;
    logic [CNT_W-1:0]        cnt;
    logic                    period_stb;
    logic                    busy;
    logic                    done;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    ev_t             exp_q[$];
    int              tests = 0;
    int              fails = 0;
    int              cyc   = 0;
    logic            mon_en = 1'b0;
    logic [CH_NUM-1:0] prev_pulse = '0;

    pg_multi_core #(
        .CH_NUM  (CH_NUM),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) dut (
        .i_clk        (clk),
        .i_res_n      (res_n),
        .i_mode       (mode),
        .i_trig       (trig),
        .i_load       (load),
        .i_period     (period),
        .i_burst_len  (burst_len),
        .i_st         (st_v),
        .i_end        (end_v),
        .i_pol        (pol_v),
        .i_ch_en      (en_v),
        .o_pulse      (pulse),
        .o_cnt        (cnt),
        .o_period_stb (period_stb),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ev_key(input ev_t e);
        return e.cyc * 64 + e.kind * 16 + e.val;
    endfunction

    function automatic void push_ev(input int c, input int k, input int v);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = 0;
        while (i < exp_q.size() && ev_key(exp_q[i]) <= ev_key(e)) i++;
        exp_q.insert(i, e);
    endfunction

    // Pulse events encode channel and new level as ch*2+level.
    function automatic void push_period(input int t, input bit with_ch2);
        push_ev(t, K_STB, 0);
        push_ev(t + 3, K_PULSE, 1);
        push_ev(t + 6, K_PULSE, 0);
        if (with_ch2) begin
            push_ev(t + 1, K_PULSE, 4);
            push_ev(t + 2, K_PULSE, 5);
        end
    endfunction

    function automatic void check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void got(input int k, input int v);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d val %0d at cyc %0d, required none", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.val != v) begin
                fails++;
                $display("FAIL event: got kind %0d val %0d at cyc %0d, required kind %0d val %0d at cyc %0d",
                         k, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endfunction

    function automatic void check_drained(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected events never seen, first at cyc %0d kind %0d val %0d, required 0",
                     name, exp_q.size(), exp_q[0].cyc, exp_q[0].kind, exp_q[0].val);
            exp_q.delete();
        end
    endfunction

    // Monitor: every strobe, done and pulse edge is matched against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (period_stb) got(K_STB, 0);
            if (done)       got(K_DONE, 0);
            for (int ch = 0; ch < CH_NUM; ch++) begin
                if (pulse[ch] != prev_pulse[ch]) got(K_PULSE, ch * 2 + int'(pulse[ch]));
            end
        end
        prev_pulse = pulse;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic cfg_load(input int per, input int bl, input logic [3:0] pol, input logic [3:0] en);
        period    = CNT_W'(per);
        burst_len = BURST_W'(bl);
        pol_v     = pol;
        en_v      = en;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    initial begin
        int s;
        int nb;
        bit found;

        res_n     = 1'b1;
        mode      = 2'd0;
        trig      = 1'b0;
        load      = 1'b0;
        period    = '0;
        burst_len = '0;
        pol_v     = '0;
        en_v      = '0;
        // ch3: 0/0, ch2: 0/1, ch1: 5/5, ch0: 2/5
        st_v      = {24'd0, 24'd0, 24'd5, 24'd2};
        end_v     = {24'd0, 24'd1, 24'd5, 24'd5};

        #3 res_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pulse", int'(pulse), 0);
        check("rst_cnt", int'(cnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_stb", int'(period_stb), 0);
        check("rst_done", int'(done), 0);
        res_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check("idle_busy", int'(busy), 0);

        // IDLE load: ch2 polarity takes effect two cycles after the strobe is driven.
        push_ev(cyc + 2, K_PULSE, 5);
        cfg_load(9, 0, 4'b0100, 4'b0011);
        repeat (3) @(negedge clk);
        check("idle_ch2_level", int'(pulse[2]), 1);

        // Continuous run with two shadow updates and a graceful stop.
        mode = 2'd1;
        s = cyc + 1;
        push_period(s,      1'b0);
        push_period(s + 10, 1'b0);
        push_period(s + 20, 1'b0);
        push_period(s + 30, 1'b0);
        push_period(s + 35, 1'b0);
        push_period(s + 40, 1'b0);
        push_period(s + 45, 1'b0);
        push_period(s + 55, 1'b0);
        wait_until(s + 23);
        check("cont_cnt_at_load1", int'(cnt), 3);
        cfg_load(4, 0, 4'b0100, 4'b0011);
        wait_until(s + 39);
        check("cont_cnt_at_wrap_load", int'(cnt), 4);
        cfg_load(9, 0, 4'b0100, 4'b0011);
        wait_until(s + 57);
        check("cont_cnt_at_stop", int'(cnt), 2);
        mode = 2'd0;
        wait_until(s + 64);
        check("stop_last_cnt", int'(cnt), 9);
        check("stop_last_busy", int'(busy), 1);
        wait_until(s + 65);
        check("stop_idle_busy", int'(busy), 0);
        check("stop_idle_cnt", int'(cnt), 0);
        wait_until(s + 70);
        check("idle_ch2_after_run", int'(pulse[2]), 1);
        check_drained("cont_events");

        // Burst of 3 periods of 5 cycles; a second trigger mid-burst is ignored.
        cfg_load(4, 3, 4'b0100, 4'b0111);
        repeat (2) @(negedge clk);
        mode = 2'd2;
        trig = 1'b1;
        s = cyc + 1;
        push_period(s,      1'b1);
        push_period(s + 5,  1'b1);
        push_period(s + 10, 1'b1);
        push_ev(s + 15, K_DONE, 0);
        nb = 0;
        for (int c = s; c <= s + 19; c++) begin
            wait_until(c);
            trig = (c == s + 6);
            if (busy) nb++;
        end
        trig = 1'b0;
        check("burst_busy_cycles", nb, 15);
        check("burst_idle_after", int'(busy), 0);
        check("burst_idle_ch2", int'(pulse[2]), 1);
        check_drained("burst_events");

        // Asynchronous reset mid-run.
        mon_en = 1'b0;
        mode   = 2'd0;
        cfg_load(9, 0, 4'b0100, 4'b0111);
        mode  = 2'd1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cnt == CNT_W'(5)) found = 1'b1;
        end
        check("rstrun_reached_cnt5", int'(found), 1);
        res_n = 1'b0;
        #1;
        check("rstrun_pulse", int'(pulse), 0);
        check("rstrun_cnt", int'(cnt), 0);
        check("rstrun_busy", int'(busy), 0);
        check("rstrun_stb", int'(period_stb), 0);
        mode = 2'd0;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_busy", int'(busy), 0);
        check("postrst_pulse", int'(pulse), 0);
        mode = 2'd1;
        @(negedge clk);
        check("zero_cfg_busy", int'(busy), 1);
        check("zero_cfg_stb0", int'(period_stb), 1);
        @(negedge clk);
        check("zero_cfg_stb1", int'(period_stb), 1);
        check("zero_cfg_cnt", int'(cnt), 0);
        check("zero_cfg_pulse", int'(pulse), 0);
        mode = 2'd0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
